// File: rtl/pipe_pkg.sv
// Shared types for the pipe_skid_reg slice: state encoding of the two-entry skid buffer and stall counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit load-enabled register with asynchronous active-low reset to RESET_VALUE.
module pipe_data_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer (main + skid register) with fully registered in_ready.
// Optional stall counter output enabled by macro PIPE_SKID_REG_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_e      r_state;
  pipe_state_e      w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_main_from_skid;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // Handshake flags come from the state register only, so in_ready never sees out_ready.
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = BUSY;
            w_main_en   = 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = FULL;
            w_skid_en   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = BUSY;
            w_main_en        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .i_en (w_skid_en),
    .i_d  (in_data),
    .o_q  (w_skid_q)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_main_q;

`ifdef PIPE_SKID_REG_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where a word waits on downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk and rst_n.
REQ-002 Parameter WIDTH SHALL default to 32 and set the payload width in bits, legal range 1..64.
REQ-003 Parameter RESET_VALUE SHALL default to 0 and set the value loaded into all data registers on reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-013 in_fire SHALL equal in_valid & in_ready; out_fire SHALL equal out_valid & out_ready.
REQ-014 The block SHALL hold up to two words: main register (drives out_data) and skid register.
REQ-015 A 2-bit state register SHALL take values EMPTY (0 words), BUSY (main only), FULL (main and skid).
REQ-016 in_ready SHALL be 1 exactly when state is not FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly when state is not EMPTY.
REQ-018 EMPTY: in_fire -> BUSY with main <= in_data; otherwise EMPTY.
REQ-019 BUSY: in_fire & out_fire -> BUSY with main <= in_data; in_fire only -> FULL with skid <= in_data; out_fire only -> EMPTY; neither -> hold.
REQ-020 FULL: out_fire -> BUSY with main <= skid; otherwise hold; no word is accepted in FULL.
REQ-021 Latency SHALL be one cycle: a word accepted at edge N SHALL be on out_data with out_valid=1 after edge N when it enters main.
REQ-022 Order SHALL be preserved; no word SHALL be dropped or duplicated except by flush or reset.
REQ-023 flush SHALL have priority over all other events: at the next edge state SHALL become EMPTY regardless of in_fire/out_fire that cycle.
REQ-024 A word presented with in_fire in a flush cycle SHALL be discarded; a word with out_fire in a flush cycle counts as delivered.
REQ-025 Data registers SHALL load only on the transitions above; they SHALL hold their value in all other cycles, including flush.
REQ-026 While out_valid=1 and out_ready=0, out_data SHALL remain stable.

Reset
REQ-027 Asserting rst_n low SHALL immediately set state to EMPTY and main and skid to RESET_VALUE, independent of clk.
REQ-028 After reset: out_valid=0, in_ready=1, out_data=RESET_VALUE; reset mid-transfer SHALL discard all held words.

Configuration
REQ-029 With macro PIPE_SKID_REG_STATS_EN defined, the block SHALL add output stall_cnt (16 bits) that counts cycles with out_valid=1 and out_ready=0, saturates at 0xFFFF, and clears on reset and on flush.
REQ-030 Without PIPE_SKID_REG_STATS_EN, stall_cnt and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the stall counter width constant (16).
REQ-032 Sub-module pipe_data_reg SHALL be a WIDTH-bit enabled register with asynchronous active-low reset to RESET_VALUE; it SHALL be instantiated twice (main and skid).

Verification
REQ-033 Reset, then in_valid=1, in_data=0x11, out_ready=1 -> out_valid=1, out_data=0x11 one cycle later; in_ready stays 1.
REQ-034 Stream 0x01..0x08 back to back with out_ready=1 -> outputs 0x01..0x08 in order, one per cycle, no bubbles.
REQ-035 Hold out_ready=0, push 0xA1 then 0xA2 -> state FULL, in_ready=0, out_data=0xA1 stable; release out_ready -> 0xA1 then 0xA2 delivered, and in_ready=1 the cycle after 0xA1 leaves.
REQ-036 In FULL, assert flush together with in_valid=1, in_data=0xFF -> next cycle out_valid=0, in_ready=1; 0xFF never appears.
REQ-037 Drop rst_n mid-stream while FULL -> out_valid=0 and out_data=RESET_VALUE without waiting for clk.
REQ-038 With PIPE_SKID_REG_STATS_EN, hold out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF; flush -> stall_cnt=0.
